arp_rx_parser: RTL and testbench

//  Parametrised ARP receive parser on the Ethernet packet path. Accepts whole Ethernet frames on an AXI-Stream slave of any supported width.

---
 rtl/arp_rx_parser.sv | 112 +++++++++++
 tb/tb_arp_rx_parser.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/arp_rx_parser.sv
// arp_rx_parser: collects the 42-byte ARP header from an AXI-Stream Ethernet frame, validates it
// and publishes sender MAC/IP, opcode and a request-for-us flag, with saturating ok/drop counters.
module arp_rx_parser #(
    parameter int C_AXIS_DATA_WIDTH = 512,
    parameter int CNT_W             = 16,
    parameter bit CHECK_DST_MAC     = 1
) (
    input  logic                           clk,
    input  logic                           rstn,
    output logic                           rx_s_axis_tready,
    input  logic [C_AXIS_DATA_WIDTH-1:0]   rx_s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0] rx_s_axis_tkeep,
    input  logic                           rx_s_axis_tvalid,
    input  logic                           rx_s_axis_tlast,
    input  logic [47:0]                    local_mac,
    input  logic [31:0]                    local_ip,
    output logic [47:0]                    arp_src_mac,
    output logic [31:0]                    arp_src_ip,
    output logic [15:0]                    arp_opcode,
    output logic                           arp_req_for_us,
    output logic                           arp_rx_valid,
    output logic [CNT_W-1:0]               arp_ok_cnt,
    output logic [CNT_W-1:0]               arp_drop_cnt
);
    localparam int W         = C_AXIS_DATA_WIDTH;
    localparam int KB        = W / 8;
    localparam int HDR_BEATS = (336 + W - 1) / W;
    localparam int HDR_W     = HDR_BEATS * W;
    localparam int KOFF      = 41 - (HDR_BEATS - 1) * KB;
    localparam logic [2:0] LAST_BEAT = 3'(HDR_BEATS - 1);

    typedef enum logic {S_HDR, S_SKIP} state_t;

    state_t           state_q;
    logic [2:0]       beat_cnt_q;
    logic [HDR_W-1:0] hdr_q, hdr_d;
    logic [HDR_W+W-1:0] hdr_cat;
    logic [335:0]     h;
    logic             hdr_ok_q, pend_req_q;
    logic [47:0]      pend_mac_q, fin_mac;
    logic [31:0]      pend_ip_q, fin_ip;
    logic [15:0]      pend_op_q, fin_op;
    logic             last_hdr, dst_ok, chk, req, fin, fin_ok, fin_req;
    logic             unused;

    assign rx_s_axis_tready = 1'b1;
    // Frame byte 0 lands in the MSB byte of h once the header beats are shifted in.
    assign hdr_cat  = {hdr_q, rx_s_axis_tdata};
    assign hdr_d    = hdr_cat[HDR_W-1:0];
    assign h        = hdr_d[HDR_W-1 -: 336];
    assign last_hdr = beat_cnt_q == LAST_BEAT;
    assign dst_ok   = !CHECK_DST_MAC || h[335 -: 48] == '1 || h[335 -: 48] == local_mac;
    assign chk      = h[239 -: 16] == 16'h0806 && h[223 -: 16] == 16'h0001 &&
                      h[207 -: 16] == 16'h0800 && h[191 -: 8] == 8'd6 && h[183 -: 8] == 8'd4 &&
                      (h[175 -: 16] == 16'd1 || h[175 -: 16] == 16'd2) && dst_ok &&
                      rx_s_axis_tkeep[KB-1-KOFF];
    assign req      = h[175 -: 16] == 16'd1 && h[31:0] == local_ip;
    assign fin      = rx_s_axis_tvalid && rx_s_axis_tlast;
    assign fin_ok   = state_q == S_SKIP ? hdr_ok_q : last_hdr && chk;
    assign fin_mac  = state_q == S_SKIP ? pend_mac_q : h[159 -: 48];
    assign fin_ip   = state_q == S_SKIP ? pend_ip_q : h[111 -: 32];
    assign fin_op   = state_q == S_SKIP ? pend_op_q : h[175 -: 16];
    assign fin_req  = state_q == S_SKIP ? pend_req_q : req;
    assign unused   = ^{hdr_cat[HDR_W+W-1:HDR_W], hdr_d[HDR_W-337:0], h[287:240], h[79:32],
                        rx_s_axis_tkeep};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= S_HDR;
            beat_cnt_q     <= '0;
            hdr_q          <= '0;
            hdr_ok_q       <= 1'b0;
            pend_mac_q     <= '0;
            pend_ip_q      <= '0;
            pend_op_q      <= '0;
            pend_req_q     <= 1'b0;
            arp_src_mac    <= '0;
            arp_src_ip     <= '0;
            arp_opcode     <= '0;
            arp_req_for_us <= 1'b0;
            arp_rx_valid   <= 1'b0;
            arp_ok_cnt     <= '0;
            arp_drop_cnt   <= '0;
        end else begin
            arp_rx_valid <= 1'b0;
            if (rx_s_axis_tvalid && state_q == S_HDR) begin
                hdr_q      <= hdr_d;
                beat_cnt_q <= (last_hdr || rx_s_axis_tlast) ? 3'd0 : beat_cnt_q + 3'd1;
                if (last_hdr && !rx_s_axis_tlast) begin
                    state_q    <= S_SKIP;
                    hdr_ok_q   <= chk;
                    pend_mac_q <= h[159 -: 48];
                    pend_ip_q  <= h[111 -: 32];
                    pend_op_q  <= h[175 -: 16];
                    pend_req_q <= req;
                end
            end
            if (fin && state_q == S_SKIP)
                state_q <= S_HDR;
            if (fin && fin_ok) begin
                arp_src_mac    <= fin_mac;
                arp_src_ip     <= fin_ip;
                arp_opcode     <= fin_op;
                arp_req_for_us <= fin_req;
                arp_rx_valid   <= 1'b1;
                arp_ok_cnt     <= arp_ok_cnt == '1 ? arp_ok_cnt : arp_ok_cnt + CNT_W'(1);
            end
            if (fin && !fin_ok)
                arp_drop_cnt <= arp_drop_cnt == '1 ? arp_drop_cnt : arp_drop_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_arp_rx_parser.sv
// tb_arp_rx_parser: directed table-driven bench for arp_rx_parser at 512-bit and 64-bit widths,
// plus hand-written sequences for gaps, short frames, saturation and mid-frame reset.
module tb_arp_rx_parser;
    localparam logic [47:0] LMAC = 48'h020000000001;
    localparam logic [31:0] LIP  = 32'hC0A80102;
    localparam logic [47:0] SHA  = 48'h000A35010203;
    localparam logic [31:0] SPA  = 32'hC0A8010A;
    localparam logic [47:0] BC   = 48'hFFFFFFFFFFFF;

    logic clk = 1'b0, rstn = 1'b0;
    always #5 clk = ~clk;

    logic [511:0] d5 = '0;
    logic [63:0]  k5 = '0;
    logic         v5 = 1'b0, l5 = 1'b0;
    logic [63:0]  d6 = '0;
    logic [7:0]   k6 = '0;
    logic         v6 = 1'b0, l6 = 1'b0;

    logic        a_rdy, a_req, a_val, b_rdy, b_req, b_val, c_rdy, c_req, c_val;
    logic [47:0] a_mac, b_mac, c_mac;
    logic [31:0] a_ip, b_ip, c_ip;
    logic [15:0] a_op, b_op, c_op;
    logic [15:0] a_ok, a_dr, b_ok, b_dr;
    logic [1:0]  c_ok, c_dr;

    arp_rx_parser #(.C_AXIS_DATA_WIDTH(512), .CNT_W(16), .CHECK_DST_MAC(1)) dut_a (
        .clk(clk), .rstn(rstn), .rx_s_axis_tready(a_rdy), .rx_s_axis_tdata(d5),
        .rx_s_axis_tkeep(k5), .rx_s_axis_tvalid(v5), .rx_s_axis_tlast(l5),
        .local_mac(LMAC), .local_ip(LIP), .arp_src_mac(a_mac), .arp_src_ip(a_ip),
        .arp_opcode(a_op), .arp_req_for_us(a_req), .arp_rx_valid(a_val),
        .arp_ok_cnt(a_ok), .arp_drop_cnt(a_dr));
    arp_rx_parser #(.C_AXIS_DATA_WIDTH(64), .CNT_W(16), .CHECK_DST_MAC(1)) dut_b (
        .clk(clk), .rstn(rstn), .rx_s_axis_tready(b_rdy), .rx_s_axis_tdata(d6),
        .rx_s_axis_tkeep(k6), .rx_s_axis_tvalid(v6), .rx_s_axis_tlast(l6),
        .local_mac(LMAC), .local_ip(LIP), .arp_src_mac(b_mac), .arp_src_ip(b_ip),
        .arp_opcode(b_op), .arp_req_for_us(b_req), .arp_rx_valid(b_val),
        .arp_ok_cnt(b_ok), .arp_drop_cnt(b_dr));
    arp_rx_parser #(.C_AXIS_DATA_WIDTH(512), .CNT_W(2), .CHECK_DST_MAC(1)) dut_c (
        .clk(clk), .rstn(rstn), .rx_s_axis_tready(c_rdy), .rx_s_axis_tdata(d5),
        .rx_s_axis_tkeep(k5), .rx_s_axis_tvalid(v5), .rx_s_axis_tlast(l5),
        .local_mac(LMAC), .local_ip(LIP), .arp_src_mac(c_mac), .arp_src_ip(c_ip),
        .arp_opcode(c_op), .arp_req_for_us(c_req), .arp_rx_valid(c_val),
        .arp_ok_cnt(c_ok), .arp_drop_cnt(c_dr));

    int n_cmp = 0, n_bad = 0, pulses_a = 0, pulses_b = 0;
    always @(negedge clk) begin
        pulses_a <= pulses_a + int'(a_val);
        pulses_b <= pulses_b + int'(b_val);
    end

    typedef struct {
        string       nm;
        logic [47:0] dst;
        logic [15:0] et;
        logic [7:0]  hl;
        logic [15:0] op;
        logic [47:0] sha;
        logic [31:0] spa;
        logic [31:0] tpa;
        int          nb;
        logic        xv;
        logic [47:0] xmac;
        logic [31:0] xip;
        logic [15:0] xop;
        logic        xreq;
        int          xok;
        int          xdrop;
    } vec_t;
    vec_t tv[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [511:0] mk(input logic [47:0] dst, input logic [15:0] et,
        input logic [7:0] hl, input logic [15:0] op, input logic [47:0] sha,
        input logic [31:0] spa, input logic [31:0] tpa);
        logic [511:0] f = '0;
        f[511 -: 48] = dst;
        f[463 -: 48] = 48'h000A35FFFFFF;
        f[415 -: 16] = et;
        f[399 -: 16] = 16'h0001;
        f[383 -: 16] = 16'h0800;
        f[367 -: 8]  = hl;
        f[359 -: 8]  = 8'd4;
        f[351 -: 16] = op;
        f[335 -: 48] = sha;
        f[287 -: 32] = spa;
        f[207 -: 32] = tpa;
        return f;
    endfunction

    task automatic add(input string nm, input logic [47:0] dst, input logic [15:0] et,
        input logic [7:0] hl, input logic [15:0] op, input logic [47:0] sha, input logic [31:0] spa,
        input logic [31:0] tpa, input int nb, input logic xv, input logic [47:0] xmac,
        input logic [31:0] xip, input logic [15:0] xop, input logic xreq, input int xok,
        input int xdrop);
        vec_t v;
        v.nm = nm; v.dst = dst; v.et = et; v.hl = hl; v.op = op; v.sha = sha; v.spa = spa;
        v.tpa = tpa; v.nb = nb; v.xv = xv; v.xmac = xmac; v.xip = xip; v.xop = xop;
        v.xreq = xreq; v.xok = xok; v.xdrop = xdrop;
        tv.push_back(v);
    endtask

    // Single-beat frame of nb valid bytes; returns on the negedge just after the tlast edge.
    task automatic send512(input logic [511:0] f, input int nb);
        logic [63:0] ones = '1;
        @(negedge clk);
        d5 = f; k5 = ones << (64 - nb); v5 = 1'b1; l5 = 1'b1;
        @(negedge clk);
        v5 = 1'b0; l5 = 1'b0; d5 = '0;
    endtask

    task automatic send64(input logic [511:0] f, input int nbeats, input logic [7:0] last_keep,
        input bit gaps, input bit dolast);
        for (int i = 0; i < nbeats; i++) begin
            if (gaps && i > 0) begin
                @(negedge clk);
                v6 = 1'b0;
            end
            @(negedge clk);
            d6 = f[511 - 64*i -: 64];
            k6 = (i == nbeats - 1) ? last_keep : 8'hFF;
            v6 = 1'b1;
            l6 = dolast && (i == nbeats - 1);
        end
        @(negedge clk);
        v6 = 1'b0; l6 = 1'b0;
    endtask

    initial begin
        add("req",       BC, 16'h0806, 8'd6, 16'd1, SHA, SPA, LIP, 64, 1, SHA, SPA, 16'd1, 1, 1, 0);
        add("reply",     LMAC, 16'h0806, 8'd6, 16'd2, 48'h000A35AABBCC, 32'hC0A80114, LIP, 64,
            1, 48'h000A35AABBCC, 32'hC0A80114, 16'd2, 0, 2, 0);
        add("req_other", BC, 16'h0806, 8'd6, 16'd1, SHA, SPA, 32'hC0A80163, 64,
            1, SHA, SPA, 16'd1, 0, 3, 0);
        add("bad_etype", BC, 16'h0800, 8'd6, 16'd1, SHA, SPA, LIP, 64, 0, SHA, SPA, 16'd1, 0, 3, 1);
        add("bad_hlen",  BC, 16'h0806, 8'd8, 16'd1, SHA, SPA, LIP, 64, 0, SHA, SPA, 16'd1, 0, 3, 2);
        add("bad_dst",   48'h112233445566, 16'h0806, 8'd6, 16'd1, SHA, SPA, LIP, 64,
            0, SHA, SPA, 16'd1, 0, 3, 3);
        add("keep40",    BC, 16'h0806, 8'd6, 16'd1, SHA, SPA, LIP, 40, 0, SHA, SPA, 16'd1, 0, 3, 4);
        add("after_short", BC, 16'h0806, 8'd6, 16'd1, SHA, SPA, LIP, 64,
            1, SHA, SPA, 16'd1, 1, 4, 4);
        add("bad_oper3", BC, 16'h0806, 8'd6, 16'd3, SHA, SPA, LIP, 64, 0, SHA, SPA, 16'd1, 1, 4, 5);
        add("keep42",    BC, 16'h0806, 8'd6, 16'd1, 48'h000A35010204, 32'hC0A8010B, LIP, 42,
            1, 48'h000A35010204, 32'hC0A8010B, 16'd1, 1, 5, 5);

        repeat (2) @(negedge clk);
        chk("rst_tready", {a_rdy, b_rdy, c_rdy}, 3'b111);
        chk("rst_a_out", {a_mac, a_ip, a_op, a_req, a_val}, '0);
        chk("rst_cnts", {a_ok, a_dr, b_ok, b_dr, c_ok, c_dr}, '0);
        chk("rst_b_out", {b_mac, b_ip, b_op, b_req, b_val}, '0);
        rstn = 1'b1;

        for (int i = 0; i < tv.size(); i++) begin
            send512(mk(tv[i].dst, tv[i].et, tv[i].hl, tv[i].op, tv[i].sha, tv[i].spa, tv[i].tpa),
                    tv[i].nb);
            chk({tv[i].nm, "_valid"}, a_val, tv[i].xv);
            chk({tv[i].nm, "_mac"}, a_mac, tv[i].xmac);
            chk({tv[i].nm, "_ip"}, a_ip, tv[i].xip);
            chk({tv[i].nm, "_op"}, a_op, tv[i].xop);
            chk({tv[i].nm, "_req"}, a_req, tv[i].xreq);
            chk({tv[i].nm, "_ok"}, a_ok, 64'(tv[i].xok));
            chk({tv[i].nm, "_drop"}, a_dr, 64'(tv[i].xdrop));
        end
        @(negedge clk);
        chk("a_valid_low", a_val, 0);
        chk("c_ok_sat", c_ok, 3);
        chk("c_drop_sat", c_dr, 3);

        send64(mk(BC, 16'h0806, 8'd6, 16'd1, SHA, SPA, LIP), 8, 8'hFF, 1, 1);
        chk("w64_gap_valid", b_val, 1);
        chk("w64_gap_fields", {b_mac, b_ip, b_op, b_req}, {SHA, SPA, 16'd1, 1'b1});
        chk("w64_gap_cnts", {b_ok, b_dr}, {16'd1, 16'd0});
        send64(mk(BC, 16'h0806, 8'd6, 16'd1, SHA, SPA, LIP), 3, 8'hFF, 0, 1);
        chk("w64_short_valid", b_val, 0);
        chk("w64_short_cnts", {b_ok, b_dr}, {16'd1, 16'd1});
        chk("w64_short_hold", b_mac, SHA);
        send64(mk(BC, 16'h0806, 8'd6, 16'd1, 48'h000A35010204, 32'hC0A8010B, LIP), 8, 8'hFF, 0, 1);
        chk("w64_next_valid", b_val, 1);
        chk("w64_next_fields", {b_mac, b_ip}, {48'h000A35010204, 32'hC0A8010B});
        chk("w64_next_ok", b_ok, 2);
        send64(mk(BC, 16'h0806, 8'd6, 16'd2, SHA, SPA, LIP), 6, 8'hC0, 0, 1);
        chk("w64_exact_valid", b_val, 1);
        chk("w64_exact_fields", {b_mac, b_op, b_req}, {SHA, 16'd2, 1'b0});
        chk("w64_exact_ok", b_ok, 3);
        send64(mk(BC, 16'h0806, 8'd6, 16'd1, SHA, SPA, LIP), 6, 8'h80, 0, 1);
        chk("w64_keep41_valid", b_val, 0);
        chk("w64_keep41_cnts", {b_ok, b_dr}, {16'd3, 16'd2});

        send64(mk(BC, 16'h0806, 8'd6, 16'd1, SHA, SPA, LIP), 3, 8'hFF, 0, 0);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("midrst_b_out", {b_mac, b_ip, b_op, b_req, b_val}, '0);
        chk("midrst_cnts", {b_ok, b_dr, a_ok, a_dr, c_ok, c_dr}, '0);
        @(negedge clk);
        rstn = 1'b1;
        send64(mk(BC, 16'h0806, 8'd6, 16'd1, SHA, SPA, LIP), 8, 8'hFF, 0, 1);
        chk("postrst_valid", b_val, 1);
        chk("postrst_fields", {b_mac, b_ip, b_op, b_req}, {SHA, SPA, 16'd1, 1'b1});
        chk("postrst_cnts", {b_ok, b_dr}, {16'd1, 16'd0});

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            d5 = mk(BC, 16'h0806, 8'd6, 16'd1, SHA, SPA, LIP); k5 = '1; v5 = 1'b1; l5 = 1'b1;
            if (i > 0) chk($sformatf("b2b_pulse%0d", i), c_val, 1);
        end
        @(negedge clk);
        v5 = 1'b0; l5 = 1'b0;
        chk("b2b_pulse5", c_val, 1);
        chk("b2b_c_ok_sat", c_ok, 3);
        chk("b2b_a_ok", a_ok, 5);
        chk("b2b_c_drop", c_dr, 0);
        @(negedge clk);
        chk("b2b_end_low", c_val, 0);
        @(posedge clk);
        chk("pulses_a", 64'(pulses_a), 10);
        chk("pulses_b", 64'(pulses_b), 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
